// File: rtl/adc_sample_conditioner_if.sv
// ADC-to-I2S sample bus: raw ADC codes in, conditioned signed samples and status out.
// adc_valid and out_valid are single-cycle strobes with no back-pressure. The payload is valid only while its strobe
// is high. out_sample holds its value between strobes, clip is only meaningful alongside out_valid, and settled is a
// level signal.
interface adc_sample_conditioner_if #(
  parameter int in_res  = 12,
  parameter int out_res = 16
);
  logic                      adc_valid;
  logic [in_res-1:0]         adc_sample;
  logic signed [out_res-1:0] out_sample;
  logic                      out_valid;
  logic                      clip;
  logic                      settled;

  modport master (
    output adc_valid, adc_sample,
    input  out_sample, out_valid, clip, settled
  );

  modport slave (
    input  adc_valid, adc_sample,
    output out_sample, out_valid, clip, settled
  );
endinterface

// File: rtl/adc_sample_conditioner.sv
// Removes the DC bias from unsigned ADC samples with a first-order tracker, then applies gain and saturates.
// Output is muted until the tracker has seen settle_samples samples after its initial load.
module adc_sample_conditioner #(
  parameter int in_res         = 12,
  parameter int out_res        = 16,
  parameter int dc_shift       = 8,
  parameter int gain_shift     = 4,
  parameter int settle_samples = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  adc_sample_conditioner_if.slave    bus,
  output logic [1:0]                 state_dbg
);

  localparam int acc_w  = in_res + dc_shift;
  localparam int c_w    = in_res + 1;
  localparam int s_w    = c_w + gain_shift;
  localparam int wide_w = ((s_w > out_res) ? s_w : out_res) + 1;
  localparam int cnt_w  = (settle_samples > 1) ? $clog2(settle_samples) : 1;

  localparam logic signed [wide_w-1:0] sat_max = wide_w'((longint'(1) <<< (out_res - 1)) - 1);
  localparam logic signed [wide_w-1:0] sat_min = ~sat_max;

  typedef enum logic [1:0] {
    s_idle   = 2'd0,
    s_settle = 2'd1,
    s_run    = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [acc_w-1:0]  acc, acc_next, acc_upd;
  logic [cnt_w-1:0]  cnt, cnt_next;
  logic [in_res-1:0] dc;

  logic                  s1_valid;
  logic                  s1_mute;
  logic signed [c_w-1:0] s1_c;
  logic signed [c_w-1:0] c_comb;

  logic signed [wide_w-1:0]  s_wide;
  logic                      sat_hi, sat_lo;
  logic signed [out_res-1:0] sat_val;

  logic signed [out_res-1:0] out_sample_q;
  logic                      out_valid_q;
  logic                      clip_q;

  assign dc = acc[acc_w-1:dc_shift];
  // acc - dc never underflows and the sum never exceeds 2^acc_w - 1, so acc_w bits are enough.
  assign acc_upd = acc + acc_w'(bus.adc_sample) - acc_w'(dc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= s_idle;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    if (bus.adc_valid) begin
      unique case (state)
        s_idle: begin
          acc_next   = {bus.adc_sample, {dc_shift{1'b0}}};
          cnt_next   = '0;
          state_next = s_settle;
        end
        s_settle: begin
          acc_next = acc_upd;
          cnt_next = cnt + 1'b1;
          if (cnt == cnt_w'(settle_samples - 1)) state_next = s_run;
        end
        s_run: begin
          acc_next = acc_upd;
        end
        default: state_next = s_idle;
      endcase
    end
  end

  // Centre against the dc in effect before this sample updates the tracker.
  assign c_comb = (state == s_idle) ? '0
                : $signed({1'b0, bus.adc_sample}) - $signed({1'b0, dc});

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mute  <= 1'b0;
      s1_c     <= '0;
    end else begin
      s1_valid <= bus.adc_valid;
      if (bus.adc_valid) begin
        s1_c    <= c_comb;
        s1_mute <= (state != s_run);
      end
    end
  end

  assign s_wide  = wide_w'(s1_c) <<< gain_shift;
  assign sat_hi  = (s_wide > sat_max);
  assign sat_lo  = (s_wide < sat_min);
  assign sat_val = sat_hi ? sat_max[out_res-1:0]
                 : sat_lo ? sat_min[out_res-1:0]
                 : s_wide[out_res-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      clip_q       <= 1'b0;
    end else begin
      out_valid_q <= s1_valid;
      clip_q      <= s1_valid && !s1_mute && (sat_hi || sat_lo);
      if (s1_valid) out_sample_q <= s1_mute ? '0 : sat_val;
    end
  end

  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.clip       = clip_q;
  assign bus.settled    = (state == s_run);
  assign state_dbg      = state;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed bench for adc_sample_conditioner with settle_samples=4; expected values are hand-computed.
module tb_adc_sample_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_pass  = 0;
  int         n_total = 0;

  logic [15:0] exp_q[$];

  adc_sample_conditioner_if #(.in_res(12), .out_res(16)) bus_if ();

  adc_sample_conditioner #(
    .in_res(12), .out_res(16), .dc_shift(8), .gain_shift(4), .settle_samples(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.adc_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // One sample, then 7 idle cycles: checks latency, pulse width, value, clip, settled and hold.
  task automatic send(input string tag, input int x, input int exp, input int exp_clip, input int exp_settled);
    bus_if.adc_valid  = 1'b1;
    bus_if.adc_sample = x[11:0];
    step();
    bus_if.adc_valid = 1'b0;
    check({tag, "_early"}, bus_if.out_valid, 0);
    step();
    check({tag, "_ov"},      bus_if.out_valid, 1);
    check({tag, "_val"},     $signed(bus_if.out_sample), exp);
    check({tag, "_clip"},    bus_if.clip, exp_clip);
    check({tag, "_settled"}, bus_if.settled, exp_settled);
    step();
    check({tag, "_ov_low"},   bus_if.out_valid, 0);
    check({tag, "_clip_low"}, bus_if.clip, 0);
    check({tag, "_hold"},     $signed(bus_if.out_sample), exp);
    repeat (5) step();
  endtask

  initial begin
    int prev;
    int val;

    // 1: reset with adc_valid asserted
    rst = 1'b1;
    bus_if.adc_valid  = 1'b1;
    bus_if.adc_sample = 12'd2048;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_ov",      bus_if.out_valid, 0);
      check("rst_out",     $signed(bus_if.out_sample), 0);
      check("rst_clip",    bus_if.clip, 0);
      check("rst_settled", bus_if.settled, 0);
      check("rst_state",   state_dbg, 0);
    end
    rst = 1'b0;
    bus_if.adc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_ov", bus_if.out_valid, 0);
      check("post_rst_state", state_dbg, 0);
    end

    // 2: IDLE + 4 SETTLE samples muted, then RUN
    for (int i = 1; i <= 6; i++) send($sformatf("settle%0d", i), 2048, 0, 0, (i >= 5) ? 1 : 0);
    check("run_state", state_dbg, 2);

    // 3: dc=2048 centring, then exact negative full scale without clip
    send("pos52", 2100, 832, 0, 1);
    send("neg52", 1996, -832, 0, 1);
    send("neg_fs", 0, -32768, 0, 1);

    // 4: positive and negative saturation
    do_reset();
    for (int i = 0; i < 5; i++) send("dc1000_init", 1000, 0, 0, (i == 4) ? 1 : 0);
    send("clip_hi", 4095, 32767, 1, 1);
    do_reset();
    for (int i = 0; i < 5; i++) send("dc3000_init", 3000, 0, 0, (i == 4) ? 1 : 0);
    send("clip_lo", 0, -32768, 1, 1);

    // 5: back-to-back step from 2048 to 3000
    do_reset();
    exp_q = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd15008, 16'd14944};
    prev = 32767;
    for (int i = 1; i <= 33; i++) begin
      bus_if.adc_valid  = (i <= 31);
      bus_if.adc_sample = (i == 1) ? 12'd2048 : 12'd3000;
      step();
      if (i >= 2 && i <= 32) begin
        check("b2b_ov", bus_if.out_valid, 1);
        val = $signed(bus_if.out_sample);
        if (exp_q.size() > 0) begin
          check("b2b_val", val, $signed(exp_q.pop_front()));
        end else begin
          check("b2b_decay", (val <= prev) ? 1 : 0, 1);
          check("b2b_pos", (val > 0) ? 1 : 0, 1);
        end
        if (i >= 7) prev = val;
      end else if (i == 33) begin
        check("b2b_drain", bus_if.out_valid, 0);
      end
    end
    bus_if.adc_valid = 1'b0;
    step();

    // 6: reset mid-RUN with two samples in flight
    do_reset();
    for (int i = 0; i < 5; i++) send("pre_init", 2048, 0, 0, (i == 4) ? 1 : 0);
    send("pre_val", 2100, 832, 0, 1);
    bus_if.adc_valid  = 1'b1;
    bus_if.adc_sample = 12'd2100;
    step();
    rst = 1'b1;
    bus_if.adc_sample = 12'd2200;
    step();
    rst = 1'b0;
    bus_if.adc_valid = 1'b0;
    check("mid_rst_ov",      bus_if.out_valid, 0);
    check("mid_rst_out",     $signed(bus_if.out_sample), 0);
    check("mid_rst_settled", bus_if.settled, 0);
    check("mid_rst_state",   state_dbg, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_drain", bus_if.out_valid, 0);
    end
    for (int i = 0; i < 5; i++) send("reinit", 1500, 0, 0, (i == 4) ? 1 : 0);
    send("reinit_dc", 1510, 160, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
